video_timing_rx: RTL and testbench

- Receive-side counterpart of the team's HDMI/VGA timing source.
- Consumes a parallel video stream (pixel clock domain: de, hs, vs, 8-bit R/G/B) and re-times the pixel data through a 2-stage pipeline.
- Annotates each pixel with x/y coordinates, start-of-frame and end-of-line flags.
- Measures active width/height and reports lock/error status to downstream vision processing.

---
 rtl/video_timing_rx.sv | 146 ++++++++++++++
 tb/tb_video_timing_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_rx.sv
// Video timing receiver: re-times a de/hs/vs pixel stream by two clocks, tags each
// pixel with x/y/sof/eol, and measures and locks onto the active frame geometry.
module video_timing_rx #(
  parameter int XW     = 11,
  parameter int YW     = 11,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_de,
  input  logic          in_hs,
  input  logic          in_vs,
  input  logic [7:0]    in_r,
  input  logic [7:0]    in_g,
  input  logic [7:0]    in_b,
  output logic          o_de,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_sof,
  output logic          o_eol,
  output logic [XW-1:0] o_width,
  output logic [YW-1:0] o_height,
  output logic          o_locked,
  output logic          o_err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t r_state, w_state_nxt;

  logic          r_de1, r_hs1, r_vs1, r_de_d, r_vs_d;
  logic [7:0]    r_r1, r_g1, r_b1;
  logic [XW-1:0] r_xc, r_cand, w_xcur, w_xinc, w_cand;
  logic [YW-1:0] r_yc, w_ycur, w_yend;
  logic          r_first, r_trunc, r_have, r_mis;
  logic          w_vs_edge, w_de_rise, w_de_fall, w_run, w_line_ok, w_cand_bad;
  logic          w_err, w_lock;
  logic          w_unused_hs;

  // hs carries nothing the counters need; it is only re-timed with the rest.
  assign w_unused_hs = r_hs1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_de1 <= 1'b0; r_hs1 <= 1'b0; r_vs1 <= 1'b0;
      r_de_d <= 1'b0; r_vs_d <= 1'b0;
      r_r1 <= '0; r_g1 <= '0; r_b1 <= '0;
    end else begin
      r_de1  <= in_de;
      r_hs1  <= (in_hs == HS_POL);
      r_vs1  <= (in_vs == VS_POL);
      r_de_d <= r_de1;
      r_vs_d <= r_vs1;
      r_r1   <= in_r; r_g1 <= in_g; r_b1 <= in_b;
    end
  end

  assign w_vs_edge  = r_vs1 & ~r_vs_d;
  assign w_de_rise  = r_de1 & ~r_de_d;
  assign w_de_fall  = ~r_de1 & r_de_d;
  assign w_run      = (r_state != SEARCH) | w_vs_edge;
  // A line already in flight at vs_edge belongs to no frame; its end is ignored.
  assign w_line_ok  = w_de_fall & ~r_trunc & (r_state != SEARCH);
  assign w_xcur     = w_de_rise ? '0 : r_xc;
  assign w_xinc     = (w_xcur == {XW{1'b1}}) ? w_xcur : w_xcur + XW'(1);
  assign w_ycur     = w_vs_edge ? '0 : r_yc;
  // Line count including a line that ends on this very cycle.
  assign w_yend     = (w_line_ok && r_yc != {YW{1'b1}}) ? r_yc + YW'(1) : r_yc;
  assign w_cand     = r_have ? r_cand : r_xc;
  assign w_cand_bad = w_line_ok & r_have & (r_xc != r_cand);

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_lock      = 1'b0;
    case (r_state)
      SEARCH:  if (w_vs_edge) w_state_nxt = MEASURE;
      MEASURE: if (w_vs_edge && w_yend != '0 && !r_mis && !w_cand_bad) begin
        w_lock      = 1'b1;
        w_state_nxt = LOCKED;
      end
      LOCKED:  if ((w_line_ok && r_xc != o_width) || (w_vs_edge && w_yend != o_height)) begin
        w_err       = 1'b1;
        w_state_nxt = MEASURE;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_de <= 1'b0; o_r <= '0; o_g <= '0; o_b <= '0;
      o_x <= '0; o_y <= '0; o_sof <= 1'b0; o_eol <= 1'b0;
      o_width <= '0; o_height <= '0; o_locked <= 1'b0; o_err <= 1'b0;
      r_xc <= '0; r_yc <= '0; r_cand <= '0;
      r_first <= 1'b0; r_trunc <= 1'b0; r_have <= 1'b0; r_mis <= 1'b0;
    end else begin
      o_de  <= r_de1;
      o_r   <= r_r1; o_g <= r_g1; o_b <= r_b1;
      o_eol <= r_de1 & ~in_de;
      o_sof <= w_de_rise & (r_first | w_vs_edge);
      o_x   <= w_xcur;
      o_y   <= w_ycur;
      o_err <= w_err;
      if (w_lock) begin
        o_width  <= w_cand;
        o_height <= w_yend;
        o_locked <= 1'b1;
      end
      if (w_err) o_locked <= 1'b0;
      if (w_run) begin
        if (r_de1) r_xc <= w_xinc;
        if (w_vs_edge)      r_yc <= '0;
        else if (w_line_ok) r_yc <= w_yend;
        if (w_vs_edge)      r_first <= ~w_de_rise;
        else if (w_de_rise) r_first <= 1'b0;
        if (w_vs_edge)      r_trunc <= r_de1 & r_de_d;
        else if (w_de_fall) r_trunc <= 1'b0;
        if (w_vs_edge) begin
          r_have <= 1'b0;
          r_mis  <= 1'b0;
        end else begin
          if (w_line_ok && r_state == MEASURE) begin
            if (!r_have) begin
              r_cand <= r_xc;
              r_have <= 1'b1;
            end else if (w_cand_bad) begin
              r_mis <= 1'b1;
            end
          end
          // A width error mid-frame spoils the remainder of that frame as a candidate.
          if (w_err) r_mis <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx: builds a frame-level stimulus stream, derives the expected
// per-pixel annotations and lock/error behaviour from it, and checks two polarity variants.
module tb_video_timing_rx;
  localparam int XW = 11;
  localparam int YW = 11;

  typedef struct packed {
    logic rst, de, hs, vs;
    logic [7:0] r, g, b;
  } in_t;

  typedef struct packed {
    logic de;
    logic [7:0] r, g, b;
    logic [XW-1:0] x, w;
    logic [YW-1:0] y, h;
    logic sof, eol, lck, err;
  } ex_t;

  logic clk = 1'b0;
  logic rst, in_de, in_hs, in_vs, in_hs_n, in_vs_n;
  logic [7:0] in_r, in_g, in_b;

  logic a_de, a_sof, a_eol, a_lck, a_err;
  logic [7:0] a_r, a_g, a_b;
  logic [XW-1:0] a_x, a_w;
  logic [YW-1:0] a_y, a_h;
  logic b_de, b_sof, b_eol, b_lck, b_err;
  logic [7:0] b_r, b_g, b_b;
  logic [XW-1:0] b_x, b_w;
  logic [YW-1:0] b_y, b_h;

  in_t stim[$];
  ex_t exq[$];
  int  n_cmp = 0, n_bad = 0, cyc = 0;
  int  n_err_a = 0, n_err_b = 0, n_err_exp = 0;

  always #5 clk = ~clk;

  assign in_hs_n = ~in_hs;
  assign in_vs_n = ~in_vs;

  video_timing_rx #(.XW(XW), .YW(YW), .HS_POL(1'b1), .VS_POL(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .o_de(a_de), .o_r(a_r), .o_g(a_g), .o_b(a_b), .o_x(a_x), .o_y(a_y),
    .o_sof(a_sof), .o_eol(a_eol), .o_width(a_w), .o_height(a_h),
    .o_locked(a_lck), .o_err(a_err));

  video_timing_rx #(.XW(XW), .YW(YW), .HS_POL(1'b0), .VS_POL(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs_n), .in_vs(in_vs_n),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .o_de(b_de), .o_r(b_r), .o_g(b_g), .o_b(b_b), .o_x(b_x), .o_y(b_y),
    .o_sof(b_sof), .o_eol(b_eol), .o_width(b_w), .o_height(b_h),
    .o_locked(b_lck), .o_err(b_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic push(input logic r_, input logic d, input logic h, input logic v,
                      input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    in_t s;
    s.rst = r_; s.de = d; s.hs = h; s.vs = v; s.r = rr; s.g = gg; s.b = bb;
    stim.push_back(s);
  endtask

  // One frame: vsync lines, back porch, nl active lines (line bad_ln is bad_w wide), front porch.
  task automatic add_frame(input int nl, input int w, input int bad_ln, input int bad_w,
                           input int hsw, input int hbp, input int hfp,
                           input int vsw, input int vbp, input int vfp);
    int wpad, aw, y;
    bit act, d;
    wpad = (bad_w > w) ? bad_w : w;
    for (int l = 0; l < vsw + vbp + nl + vfp; l++) begin
      y   = l - (vsw + vbp);
      act = (y >= 0) && (y < nl);
      aw  = (y == bad_ln) ? bad_w : w;
      for (int c = 0; c < hsw + hbp + wpad + hfp; c++) begin
        d = act && (c >= hsw + hbp) && (c < hsw + hbp + aw);
        push(1'b0, d, c < hsw, l < vsw,
             d ? 8'(c - hsw - hbp) : 8'($urandom),
             d ? 8'(y) : 8'($urandom), 8'($urandom));
      end
    end
  endtask

  task automatic std(input int nl);
    add_frame(nl, 8, -1, 0, 2, 8, 8, 4, 8, 8);
  endtask

  // Expected outputs per input cycle, from the stream's line/frame structure.
  task automatic build_exp();
    bit syn, lck, disc, sofp, pde, pvs, vs_rise, de_fall, de_rise, err, same;
    int W, H, lines, cnt;
    int ws[$];
    in_t s;
    ex_t e;
    syn = 0; lck = 0; disc = 0; sofp = 0; pde = 0; pvs = 0;
    W = 0; H = 0; lines = 0; cnt = 0;
    for (int k = 0; k < stim.size(); k++) begin
      s = stim[k];
      e = '0;
      if (s.rst) begin
        exq.push_back(e);
        if (k > 0) exq[k-1] = '0;
        syn = 0; lck = 0; disc = 0; sofp = 0; pde = 0; pvs = 0;
        W = 0; H = 0; lines = 0; cnt = 0; ws.delete();
        continue;
      end
      vs_rise = s.vs && !pvs;
      de_fall = !s.de && pde;
      de_rise = s.de && !pde;
      err = 0;
      if (de_fall && syn) begin
        lines++;
        if (lck) begin
          if (cnt != W) begin err = 1; lck = 0; disc = 1; end
        end else ws.push_back(cnt);
      end
      if (vs_rise) begin
        if (syn) begin
          if (lck) begin
            if (lines != H) begin err = 1; lck = 0; end
          end else if (!disc && lines > 0) begin
            same = 1;
            foreach (ws[i]) if (ws[i] != ws[0]) same = 0;
            if (same) begin lck = 1; W = ws[0]; H = lines; end
          end
        end
        syn = 1; disc = 0; lines = 0; sofp = 1; ws.delete();
      end
      if (s.de) begin
        if (de_rise) cnt = 0;
        e.x = syn ? XW'(cnt) : '0;
        e.y = syn ? YW'(lines) : '0;
        e.sof = syn && de_rise && sofp;
        if (de_rise) sofp = 0;
        cnt++;
      end
      e.eol = s.de && ((k + 1 < stim.size()) ? !stim[k+1].de : 1'b1);
      e.de = s.de; e.r = s.r; e.g = s.g; e.b = s.b;
      e.w = XW'(W); e.h = YW'(H); e.lck = lck; e.err = err;
      exq.push_back(e);
      pde = s.de; pvs = s.vs;
    end
  endtask

  task automatic cmp_out(input string p, input ex_t e, input logic de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic sof, input logic eol,
                         input logic [XW-1:0] w, input logic [YW-1:0] h,
                         input logic lck, input logic err);
    chk({p, ".de"}, 32'(de), 32'(e.de));
    chk({p, ".rgb"}, {8'h0, r, g, b}, {8'h0, e.r, e.g, e.b});
    if (e.de) begin
      chk({p, ".x"}, 32'(x), 32'(e.x));
      chk({p, ".y"}, 32'(y), 32'(e.y));
    end
    chk({p, ".sof"}, 32'(sof), 32'(e.sof));
    chk({p, ".eol"}, 32'(eol), 32'(e.eol));
    chk({p, ".width"}, 32'(w), 32'(e.w));
    chk({p, ".height"}, 32'(h), 32'(e.h));
    chk({p, ".locked"}, 32'(lck), 32'(e.lck));
    chk({p, ".err"}, 32'(err), 32'(e.err));
  endtask

  task automatic check_at(input int k);
    cyc = k;
    cmp_out("a", exq[k], a_de, a_r, a_g, a_b, a_x, a_y, a_sof, a_eol, a_w, a_h, a_lck, a_err);
    cmp_out("b", exq[k], b_de, b_r, b_g, b_b, b_x, b_y, b_sof, b_eol, b_w, b_h, b_lck, b_err);
    n_err_a   += int'(a_err);
    n_err_b   += int'(b_err);
    n_err_exp += int'(exq[k].err);
  endtask

  initial begin
    int st, bw, bh, nl, bad, badw;
    in_t tmp;
    rst = 1'b1; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;

    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    repeat (3) std(4);                     // lock at second vs edge
    add_frame(4, 8, 2, 7, 2, 8, 8, 4, 8, 8); // short line while locked
    repeat (3) std(4);
    std(3);                                // wrong line count while locked
    repeat (3) std(3);                     // relock with height 3
    repeat (3) std(4);
    st = stim.size();
    std(4);                                // reset mid-line while locked
    tmp = stim[st + (4 + 8 + 1) * 26 + 2 + 8 + 3];
    tmp.rst = 1'b1;
    stim[st + (4 + 8 + 1) * 26 + 2 + 8 + 3] = tmp;
    repeat (3) std(4);
    std(0);                                // frame without active lines
    repeat (3) std(4);

    bw = $urandom_range(1, 12);
    bh = $urandom_range(1, 4);
    for (int f = 0; f < 10; f++) begin
      nl   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : bh;
      bad  = (nl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      badw = ($urandom_range(0, 1) == 1) ? bw + 1 : bw - 1;
      add_frame(nl, bw, bad, badw, $urandom_range(1, 3), $urandom_range(1, 4),
                $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3));
    end
    add_frame(0, 4, -1, 0, 1, 1, 1, 2, 1, 1);

    build_exp();

    for (int k = 0; k < stim.size(); k++) begin
      rst = stim[k].rst; in_de = stim[k].de; in_hs = stim[k].hs; in_vs = stim[k].vs;
      in_r = stim[k].r; in_g = stim[k].g; in_b = stim[k].b;
      @(posedge clk);
      #1;
      if (k > 0) check_at(k - 1);
    end
    rst = 1'b0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
    @(posedge clk);
    #1;
    check_at(stim.size() - 1);

    chk("a.errcnt", 32'(n_err_a), 32'(n_err_exp));
    chk("b.errcnt", 32'(n_err_b), 32'(n_err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
